// File: rtl/simplebus_host_arbiter.sv
// -----------------------------------------------------------------------------
// simplebus_host_arbiter
//
// Host-side controller for the byte-serial simplebus. Two internal requesters
// are arbitrated round-robin; the granted transaction is serialised onto the
// 8-bit odd-parity bus (command, address, select, data, LSB first), the device
// ack is awaited, read data is collected and a single-cycle response is
// returned to the requester that owns the transaction.
//
// Ports:
//   clk          system clock, bus bytes launched/sampled on rising edge
//   rst          asynchronous active-high reset
//   req_valid    per-requester request valid (bit n = requester n)
//   req_we       per-requester write enable (1 = write, 0 = read)
//   req_addr     per-requester byte address, requester n at [32n+31:32n]
//   req_sel      per-requester byte select, requester n at [8n+7:8n]
//   req_wdata    per-requester write data, requester n at [64n+63:64n]
//   req_ready    accept pulse to the granted requester (same cycle as grant)
//   rsp_valid    one-cycle response pulse to the owning requester
//   rsp_rdata    read data, valid with rsp_valid
//   rsp_err      error flag, valid with rsp_valid
//   busy         high while a transaction is in flight, through the response
//   bus_out      byte to device, 0x00 when idle
//   bus_pty_out  odd parity of bus_out
//   bus_in       byte from device
//   bus_pty_in   odd parity of bus_in as driven by the device
// -----------------------------------------------------------------------------
module simplebus_host_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [63:0]   req_addr,
  input  logic [15:0]   req_sel,
  input  logic [127:0]  req_wdata,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [63:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [7:0]    bus_out,
  output logic          bus_pty_out,
  input  logic [7:0]    bus_in,
  input  logic          bus_pty_in
);

  localparam logic [7:0]  OP_READ      = 8'h02;
  localparam logic [7:0]  OP_WRITE     = 8'h03;
  localparam logic [7:0]  OP_READ_ACK  = 8'h82;
  localparam logic [7:0]  OP_WRITE_ACK = 8'h83;
  localparam logic [3:0]  WR_BYTES     = 4'd14;
  localparam logic [3:0]  RD_BYTES     = 4'd5;
  // The idle sample that would make the wait count reach TIMEOUT_CYCLES
  // ends the wait with an error.
  localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RECV     = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         owner_q, owner_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   sel_q, sel_d;
  logic [63:0]  wdata_q, wdata_d;
  logic [63:0]  rdata_q, rdata_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]  tmo_cnt_q, tmo_cnt_d;
  logic         err_q, err_d;
  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic [63:0]  rsp_rdata_q, rsp_rdata_d;
  logic         rsp_err_q, rsp_err_d;
  logic         busy_q, busy_d;
  logic [7:0]   bus_out_q, bus_out_d;
  logic         bus_pty_q, bus_pty_d;

  logic         gnt_s;
  logic [1:0]   req_ready_s;
  logic [7:0]   send_byte_s;
  logic         pty_ok_s;

  assign pty_ok_s = (bus_pty_in == odd_parity(bus_in));

  // Round-robin pick: on a tie the requester that did not win last time.
  always_comb begin
    gnt_s = 1'b0;
    case (req_valid)
      2'b01:   gnt_s = 1'b0;
      2'b10:   gnt_s = 1'b1;
      2'b11:   gnt_s = ~last_q;
      default: gnt_s = 1'b0;
    endcase
  end

  // Byte to launch next during SEND; index 0 (the opcode) is loaded at grant.
  always_comb begin
    send_byte_s = 8'h00;
    case (byte_cnt_q)
      4'd1:    send_byte_s = addr_q[7:0];
      4'd2:    send_byte_s = addr_q[15:8];
      4'd3:    send_byte_s = addr_q[23:16];
      4'd4:    send_byte_s = addr_q[31:24];
      4'd5:    send_byte_s = sel_q;
      4'd6:    send_byte_s = wdata_q[7:0];
      4'd7:    send_byte_s = wdata_q[15:8];
      4'd8:    send_byte_s = wdata_q[23:16];
      4'd9:    send_byte_s = wdata_q[31:24];
      4'd10:   send_byte_s = wdata_q[39:32];
      4'd11:   send_byte_s = wdata_q[47:40];
      4'd12:   send_byte_s = wdata_q[55:48];
      4'd13:   send_byte_s = wdata_q[63:56];
      default: send_byte_s = 8'h00;
    endcase
  end

  // Next-state and output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
    busy_d      = busy_q;
    bus_out_d   = 8'h00;
    req_ready_s = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = 64'h0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // req_ready is combinational; keep it quiet while reset is held.
        if ((|req_valid) && !rst) begin
          req_ready_s = gnt_s ? 2'b10 : 2'b01;
          owner_d     = gnt_s;
          last_d      = gnt_s;
          we_d        = req_we[gnt_s];
          addr_d      = gnt_s ? req_addr[63:32]   : req_addr[31:0];
          sel_d       = gnt_s ? req_sel[15:8]     : req_sel[7:0];
          wdata_d     = gnt_s ? req_wdata[127:64] : req_wdata[63:0];
          rdata_d     = 64'h0;
          err_d       = 1'b0;
          byte_cnt_d  = 4'd1;
          busy_d      = 1'b1;
          bus_out_d   = req_we[gnt_s] ? OP_WRITE : OP_READ;
          state_d     = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (byte_cnt_q == (we_q ? WR_BYTES : RD_BYTES)) begin
          bus_out_d = 8'h00;
          tmo_cnt_d = 16'd0;
          state_d   = ST_WAIT_ACK;
        end else begin
          bus_out_d  = send_byte_s;
          byte_cnt_d = byte_cnt_q + 4'd1;
        end
      end

      ST_WAIT_ACK: begin
        if (!pty_ok_s) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (bus_in == 8'h00) begin
          if (tmo_cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end else if (bus_in == (we_q ? OP_WRITE_ACK : OP_READ_ACK)) begin
          if (we_q) begin
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            byte_cnt_d = 4'd0;
            state_d    = ST_RECV;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RECV: begin
        // Bytes arrive LSB first, so shift in from the top.
        rdata_d = {bus_in, rdata_q[63:8]};
        if (!pty_ok_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (byte_cnt_q == 4'd7) begin
          state_d = ST_RESP;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end
      end

      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Load the registered response on the cycle that enters RESP.
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      rsp_valid_d = owner_q ? 2'b10 : 2'b01;
      rsp_err_d   = err_d;
      rsp_rdata_d = rdata_d;
    end else begin
      rsp_valid_d = 2'b00;
    end

    bus_pty_d = odd_parity(bus_out_d);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      sel_q       <= 8'h00;
      wdata_q     <= 64'h0;
      rdata_q     <= 64'h0;
      byte_cnt_q  <= 4'd0;
      tmo_cnt_q   <= 16'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 64'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      bus_out_q   <= 8'h00;
      bus_pty_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      bus_out_q   <= bus_out_d;
      bus_pty_q   <= bus_pty_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign bus_out     = bus_out_q;
  assign bus_pty_out = bus_pty_q;

endmodule
